// File: rtl/ps2_key_scanner.sv
// PS/2 keyboard receiver with make/break tracking and a press counter,
// feeding hex nibbles and blank flags to downstream 7-segment decoders.
module ps2_key_scanner #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 5000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    output logic             key_valid,
    output logic             frame_err,
    output logic [7:0]       key_code,
    output logic             key_held,
    output logic [CNT_W-1:0] press_cnt,
    output logic [3:0]       dig_code_lo,
    output logic [3:0]       dig_code_hi,
    output logic [3:0]       dig_cnt_lo,
    output logic [3:0]       dig_cnt_hi,
    output logic             blank_code
);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t          state, state_nx;
    logic [2:0]      clk_sync, dat_sync;
    logic            fall, bit_in;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;
    logic            par_bit;
    logic [TO_W-1:0] to_cnt;
    logic            timed_out;
    logic            frame_done, frame_ok;
    logic            break_pend;

    assign fall      = clk_sync[2] & ~clk_sync[1];
    assign bit_in    = dat_sync[2];
    // A fall on the same cycle clears the counter, so it always beats the timeout.
    assign timed_out = (state != IDLE) && !fall && (to_cnt == TO_W'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        frame_done = 1'b0;
        case (state)
            IDLE:    if (fall && !bit_in) state_nx = DATA;
            DATA:    if (fall && bit_cnt == 3'd7) state_nx = PARITY;
            PARITY:  if (fall) state_nx = STOP;
            STOP: begin
                if (fall) begin
                    frame_done = 1'b1;
                    state_nx   = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (timed_out) state_nx = IDLE;
        frame_ok = frame_done && (^{shift, par_bit}) && bit_in;
    end

    // Lines idle high, so the synchronisers start high to avoid a false fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync <= 3'b111;
            dat_sync <= 3'b111;
        end else begin
            clk_sync <= {clk_sync[1:0], ps2_clk};
            dat_sync <= {dat_sync[1:0], ps2_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt  <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
        end else begin
            if (state == IDLE || fall) to_cnt <= '0;
            else                       to_cnt <= to_cnt + TO_W'(1);

            if (state == IDLE)            bit_cnt <= '0;
            else if (state == DATA && fall) bit_cnt <= bit_cnt + 3'd1;

            if (timed_out)                           shift <= '0;
            else if (state == IDLE && fall && !bit_in) shift <= '0;
            else if (state == DATA && fall)            shift <= {bit_in, shift[7:1]};

            if (state == PARITY && fall) par_bit <= bit_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_valid  <= 1'b0;
            frame_err  <= 1'b0;
            key_code   <= '0;
            key_held   <= 1'b0;
            press_cnt  <= '0;
            break_pend <= 1'b0;
        end else begin
            key_valid <= frame_ok;
            frame_err <= frame_done && !frame_ok;
            if (frame_ok) begin
                if (shift == 8'hE0) begin
                    // Extended prefix carries no key identity on its own.
                end else if (shift == 8'hF0) begin
                    break_pend <= 1'b1;
                end else if (break_pend) begin
                    break_pend <= 1'b0;
                    if (key_held && shift == key_code) key_held <= 1'b0;
                end else if (!key_held || shift != key_code) begin
                    key_code  <= shift;
                    key_held  <= 1'b1;
                    press_cnt <= press_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign dig_code_lo = key_held ? key_code[3:0] : 4'h0;
    assign dig_code_hi = key_held ? key_code[7:4] : 4'h0;
    assign dig_cnt_lo  = press_cnt[3:0];
    assign dig_cnt_hi  = press_cnt[7:4];
    assign blank_code  = ~key_held;

endmodule

// File: tb/tb_ps2_key_scanner.sv
// Bench for ps2_key_scanner: directed scenarios plus random frames,
// checked against a key-tracking model and pulse counters.
module tb_ps2_key_scanner;
    localparam int TIMEOUT = 5000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       key_valid, frame_err, key_held, blank_code;
    logic [7:0] key_code, press_cnt;
    logic [3:0] dig_code_lo, dig_code_hi, dig_cnt_lo, dig_cnt_hi;

    always #5 clk = ~clk;

    ps2_key_scanner #(.CNT_W(8), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key_valid(key_valid), .frame_err(frame_err), .key_code(key_code),
        .key_held(key_held), .press_cnt(press_cnt),
        .dig_code_lo(dig_code_lo), .dig_code_hi(dig_code_hi),
        .dig_cnt_lo(dig_cnt_lo), .dig_cnt_hi(dig_cnt_hi), .blank_code(blank_code)
    );

    int n_cmp = 0, n_err = 0;
    int kv_seen = 0, fe_seen = 0, kv_exp = 0, fe_exp = 0;

    // Count high cycles, so a stretched pulse shows up as an extra count.
    always @(negedge clk) begin
        if (key_valid) kv_seen++;
        if (frame_err) fe_seen++;
    end

    logic [7:0] m_code;
    logic       m_held, m_brk;
    logic [7:0] m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_code = 8'h00; m_held = 1'b0; m_brk = 1'b0; m_cnt = 8'h00;
    endtask

    task automatic m_accept(input logic [7:0] c);
        if (c == 8'hE0) begin
        end else if (c == 8'hF0) begin
            m_brk = 1'b1;
        end else if (m_brk) begin
            m_brk = 1'b0;
            if (m_held && c == m_code) m_held = 1'b0;
        end else if (!m_held || c != m_code) begin
            m_code = c; m_held = 1'b1; m_cnt = m_cnt + 8'd1;
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        #(40 + $urandom_range(0, 9));
        ps2_clk = 1'b0;
        #(40 + $urandom_range(0, 9));
        ps2_clk = 1'b1;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) ps2_bit(bits[i]);
        #20 ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic bad_par, input logic bad_stop);
        logic [10:0] f;
        f = {~bad_stop, (~^c) ^ bad_par, c, 1'b0};
        send_bits(f, 11);
        repeat (10) @(posedge clk);
        if (bad_par || bad_stop) fe_exp++;
        else begin
            kv_exp++;
            m_accept(c);
        end
    endtask

    task automatic check_all(input string tag);
        #1;
        chk({tag, ".kv_pulses"}, kv_seen, kv_exp);
        chk({tag, ".err_pulses"}, fe_seen, fe_exp);
        chk({tag, ".key_held"}, {31'b0, key_held}, {31'b0, m_held});
        chk({tag, ".key_code"}, {24'b0, key_code}, {24'b0, m_code});
        chk({tag, ".press_cnt"}, {24'b0, press_cnt}, {24'b0, m_cnt});
        chk({tag, ".dig_code"}, {24'b0, dig_code_hi, dig_code_lo},
            {24'b0, m_held ? m_code : 8'h00});
        chk({tag, ".dig_cnt"}, {24'b0, dig_cnt_hi, dig_cnt_lo}, {24'b0, m_cnt});
        chk({tag, ".blank"}, {31'b0, blank_code}, {31'b0, ~m_held});
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk({tag, ".rst_key_held"}, {31'b0, key_held}, 32'd0);
        chk({tag, ".rst_press_cnt"}, {24'b0, press_cnt}, 32'd0);
        chk({tag, ".rst_key_code"}, {24'b0, key_code}, 32'd0);
        chk({tag, ".rst_blank"}, {31'b0, blank_code}, 32'd1);
        chk({tag, ".rst_pulses"}, {30'b0, key_valid, frame_err}, 32'd0);
        rst_n = 1'b1;
        m_reset();
        repeat (3) @(posedge clk);
    endtask

    initial begin
        logic [7:0] pick[3];
        logic [7:0] c, last;
        logic [10:0] partial;
        int r;
        pick[0] = 8'h1C; pick[1] = 8'h32; pick[2] = 8'h4D;
        m_reset();
        do_reset("init");
        check_all("init");

        send_frame(8'h1C, 1'b0, 1'b0);
        check_all("make_1c");

        repeat (3) send_frame(8'h1C, 1'b0, 1'b0);
        check_all("typematic");
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        check_all("break_1c");

        send_frame(8'h1C, 1'b1, 1'b0);
        check_all("bad_parity");
        send_frame(8'h1C, 1'b0, 1'b1);
        check_all("bad_stop");

        partial = {3'b111, 8'h5A, 1'b0};
        send_bits(partial, 5);
        repeat (TIMEOUT + 10) @(posedge clk);
        send_frame(8'h32, 1'b0, 1'b0);
        check_all("timeout");

        do_reset("pre");
        for (int i = 0; i < 255; i++) send_frame((i % 2 == 0) ? 8'h32 : 8'h1C, 1'b0, 1'b0);
        check_all("cnt_255");
        send_frame(8'h1C, 1'b0, 1'b0);
        check_all("cnt_wrap");

        partial = {3'b111, 8'h77, 1'b0};
        send_bits(partial, 4);
        do_reset("midframe");
        send_frame(8'h1C, 1'b0, 1'b0);
        check_all("after_rst");

        last = 8'h1C;
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 3)      c = pick[$urandom_range(0, 2)];
            else if (r <= 5) c = 8'hF0;
            else if (r == 6) c = 8'hE0;
            else if (r <= 8) c = 8'($urandom_range(0, 255));
            else             c = last;
            last = c;
            send_frame(c, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
            check_all("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
